// File: rtl/oai221_stim_pkg.sv
// oai221_stim_pkg: shared FSM type, vector constants and golden model
// for the OAI221 characterisation sequencer (optional STIM_LFSR_EN).
package oai221_stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int NUM_GRAY_VEC = 32;
  localparam int NUM_LFSR_VEC = 31;

  // shift-left Fibonacci register, feedback = s[4] ^ s[2]
  localparam logic [4:0] LFSR_SEED = 5'b00001;
  localparam logic [4:0] LFSR_TAPS = 5'b10100;

  function automatic logic golden_qn(input logic [4:0] v);
    return ~((v[0] | v[1]) & (v[2] | v[3]) & v[4]);
  endfunction

  function automatic logic [4:0] gray5(input logic [4:0] k);
    return k ^ (k >> 1);
  endfunction

endpackage

// File: rtl/stim_vec_src.sv
// stim_vec_src: vector pattern source (Gray walk, or LFSR when
// STIM_LFSR_EN is defined) with running index and last-vector flag.
module stim_vec_src
  import oai221_stim_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       step,
  input  logic       clear,
`ifdef STIM_LFSR_EN
  input  logic       mode,
`endif
  output logic [4:0] vec,
  output logic [4:0] idx,
  output logic       last
);

  // vector index, restarted on clear, advanced once per vector
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (step) begin
      idx <= idx + 5'd1;
    end
  end

`ifdef STIM_LFSR_EN
  logic [4:0] lfsr;

  // LFSR steps in lockstep with the index; never reaches zero
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lfsr <= LFSR_SEED;
    end else if (clear) begin
      lfsr <= LFSR_SEED;
    end else if (step) begin
      lfsr <= {lfsr[3:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign vec  = mode ? lfsr : gray5(idx);
  assign last = mode ? (idx == 5'(NUM_LFSR_VEC - 1))
                     : (idx == 5'(NUM_GRAY_VEC - 1));
`else
  assign vec  = gray5(idx);
  assign last = (idx == 5'(NUM_GRAY_VEC - 1));
`endif

endmodule

// File: rtl/oai221_stim_gen.sv
// oai221_stim_gen: drives an OAI221 cell, samples QN per vector and
// counts mismatches/toggles. STIM_LFSR_EN adds the MODE input.
module oai221_stim_gen
  import oai221_stim_pkg::*;
#(
  parameter int HOLD_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [HOLD_W-1:0] HOLD,
`ifdef STIM_LFSR_EN
  input  logic              MODE,
`endif
  input  logic              QN,
  output logic              IN1,
  output logic              IN2,
  output logic              IN3,
  output logic              IN4,
  output logic              IN5,
  output logic              BUSY,
  output logic              DONE,
  output logic [4:0]        VEC_IDX,
  output logic [CNT_W-1:0]  ERR_CNT,
  output logic [CNT_W-1:0]  TOG_CNT,
  output logic              FAIL
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  state_t            nstate;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hcnt;
  logic              start_acc;
  logic              sample;
  logic              prev_q;
  logic              first_q;
  logic              mis;
  logic              tgl;
  logic [4:0]        vec;
  logic [4:0]        idx;
  logic              last;
  logic              src_step;
  logic              src_clear;

  assign start_acc = (state == IDLE) && START;
  assign sample    = (state == RUN) && (hcnt == hold_q - HOLD_W'(1));
  assign src_step  = sample && !last;
  assign src_clear = start_acc || (sample && last);

`ifdef STIM_LFSR_EN
  logic mode_q;

  // pattern mode is fixed for the whole run
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q <= 1'b0;
    end else if (start_acc) begin
      mode_q <= MODE;
    end
  end
`endif

  stim_vec_src u_src (
    .CLK   (CLK),
    .RST   (RST),
    .step  (src_step),
    .clear (src_clear),
`ifdef STIM_LFSR_EN
    .mode  (mode_q),
`endif
    .vec   (vec),
    .idx   (idx),
    .last  (last)
  );

  // state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  // next state and status outputs
  always_comb begin
    nstate = state;
    BUSY   = 1'b0;
    DONE   = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (START) nstate = RUN;
      end
      (state == RUN): begin
        BUSY = 1'b1;
        if (sample && last) nstate = FIN;
      end
      (state == FIN): begin
        DONE   = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // hold length latch; a zero request behaves as one cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_q <= HOLD_W'(1);
    end else if (start_acc) begin
      hold_q <= (HOLD == '0) ? HOLD_W'(1) : HOLD;
    end
  end

  // cycles spent on the current vector
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hcnt <= '0;
    end else if (start_acc || sample) begin
      hcnt <= '0;
    end else if (state == RUN) begin
      hcnt <= hcnt + HOLD_W'(1);
    end
  end

  assign mis = (QN != golden_qn(vec));
  assign tgl = !first_q && (QN != prev_q);

  // sampler and saturating result counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ERR_CNT <= '0;
      TOG_CNT <= '0;
      prev_q  <= 1'b0;
      first_q <= 1'b1;
    end else if (start_acc) begin
      ERR_CNT <= '0;
      TOG_CNT <= '0;
      prev_q  <= 1'b0;
      first_q <= 1'b1;
    end else if (sample) begin
      if (mis && ERR_CNT != CNT_MAX) ERR_CNT <= ERR_CNT + 1'b1;
      if (tgl && TOG_CNT != CNT_MAX) TOG_CNT <= TOG_CNT + 1'b1;
      prev_q  <= QN;
      first_q <= 1'b0;
    end
  end

  assign FAIL    = (ERR_CNT != '0);
  assign VEC_IDX = BUSY ? idx : 5'd0;
  assign IN1     = BUSY & vec[0];
  assign IN2     = BUSY & vec[1];
  assign IN3     = BUSY & vec[2];
  assign IN4     = BUSY & vec[3];
  assign IN5     = BUSY & vec[4];

endmodule

// File: doc/oai221_stim_gen.md
# oai221_stim_gen

Self-checking stimulus sequencer for power and function characterisation of a 5-input OAI221 cell: IN1..IN5 of this block drive the cell's inputs directly and the cell's QN comes back here. It walks the input space in single-bit-change order, holds each vector for a programmable number of cycles, and samples QN at the end of the hold. It then compares QN against the golden OAI221 function and counts both mismatches and QN toggles. It sits directly upstream of the cell under test in the power test harness.

## Interface
- HOLD_W, 8, width of HOLD input
- CNT_W, 16, width of ERR_CNT and TOG_CNT
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- START  in  1  run request, sampled in IDLE only
- HOLD  in  HOLD_W  cycles per vector, latched on accepted START; 0 treated as 1
- QN  in  1  output of cell under test
- IN1..IN5  out  1 each  cell inputs
- BUSY  out  1  high while vectors are applied
- DONE  out  1  one-cycle completion pulse
- VEC_IDX  out  5  index of vector currently driven
- ERR_CNT  out  CNT_W  golden-model mismatches, saturating
- TOG_CNT  out  CNT_W  QN changes between consecutive samples, saturating
- FAIL  out  1  high when ERR_CNT is nonzero

## Operation
- FSM states are IDLE, RUN and FIN.
  - IDLE to RUN on START; this clears ERR_CNT, TOG_CNT and VEC_IDX and latches H = max(HOLD,1).
  - RUN to FIN after the sample of the last vector.
  - FIN to IDLE unconditionally.
- Vector k (k = 0..31) is g = k ^ (k>>1). IN1=g[0], IN2=g[1], IN3=g[2], IN4=g[3], IN5=g[4].
- Golden QN = ~((IN1|IN2) & (IN3|IN4) & IN5).
- Sample: ERR_CNT increments when the sampled QN differs from golden.
- Toggles: TOG_CNT increments when the sampled QN differs from the previous sample. Vector 0's sample is never counted as a toggle.
- Both counters saturate at 2^CNT_W-1 and hold their final values until the next accepted START.
- START is ignored in RUN and FIN.
- RST at any time, including mid-run, forces IDLE with every output at its reset value. There is no partial-result retention.

## Timing
- Reset values: IN1..IN5=0, BUSY=0, DONE=0, VEC_IDX=0, ERR_CNT=0, TOG_CNT=0, FAIL=0.
- START high in IDLE at edge 0. From cycle 1, BUSY=1 and vector 0 is driven.
- Vector k is driven for exactly H cycles. QN is sampled at the rising edge that ends its H-th cycle, and that same edge switches IN*/VEC_IDX to vector k+1.
- BUSY is high for exactly N*H cycles, with N=32 in Gray mode.
- FIN cycle (cycle N*H+1): DONE=1, BUSY=0, IN* and VEC_IDX return to 0. ERR_CNT, TOG_CNT and FAIL are final in this cycle.
- The earliest new START is accepted in cycle N*H+2.
- QN is registered at the sample edge only, with no synchroniser. The cell's combinational delay must settle within H cycles.

## Configuration
- STIM_LFSR_EN defined adds input MODE (1 bit), latched on accepted START.
  - MODE=1 selects a 5-bit Fibonacci LFSR, polynomial x^5+x^3+1, seed 5'b00001, one step per vector, N=31 vectors (all-zero never applied).
  - MODE=0 selects Gray mode.
- STIM_LFSR_EN undefined: no MODE port, Gray mode only, N=32.

## Structure
- Package oai221_stim_pkg holds:
  - FSM state enum
  - NUM_GRAY_VEC=32 and NUM_LFSR_VEC=31
  - LFSR seed and tap constants
  - function golden_qn(5-bit vector)
- Sub-module stim_vec_src is the pattern source. It takes step/clear (plus mode under the macro) and produces the vector, VEC_IDX and a last flag.
- The top holds the FSM, hold counter, sampler and the two counters.

## Test plan
- Ideal OAI221 model on QN, HOLD=1 -> BUSY high 32 cycles, DONE at cycle 33, ERR_CNT=0, TOG_CNT=4, FAIL=0.
- QN stuck at 1, HOLD=1 -> ERR_CNT=9, TOG_CNT=0, FAIL=1. QN stuck at 0 -> ERR_CNT=23, TOG_CNT=0.
- HOLD=0 versus HOLD=1 -> identical cycle count. HOLD=5 -> each vector held 5 cycles, BUSY high 160 cycles, results unchanged.
- START re-pulsed during RUN and during FIN -> ignored, run length unchanged. START in cycle N*H+2 -> new run with counters cleared.
- RST asserted at vector 10 -> all outputs to reset values asynchronously; following START -> clean full run.
- STIM_LFSR_EN with MODE=1 and ideal model -> 31 vectors starting at 5'b00001, ERR_CNT=0, DONE at cycle 31*H+1.
